button_event_classifier: RTL and testbench
==========================================

BUTTON_EVENT_CLASSIFIER -- requirements
Module: button_event_classifier

Interface
REQ-001 Parameter LONG_CYCLES, default 50_000_000, press duration in clk cycles (0.5 s at 100 MHz) that classifies a long press; SHALL be >= 2.
REQ-002 Parameter GAP_CYCLES, default 25_000_000, maximum release-to-repress gap in clk cycles for a double click; SHALL be >= 2.
REQ-003 Parameter CNT_W, default 26, timer width; SHALL satisfy 2**CNT_W > max(LONG_CYCLES, GAP_CYCLES).
REQ-004 clk  input  1  single system clock, 100 MHz, all logic on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 stableSignal  input  1  debounced button level from the upstream debouncer, synchronous to clk.
REQ-007 shortPress  output  1  one-cycle pulse: a short press was classified.
REQ-008 longPress  output  1  one-cycle pulse: press held for LONG_CYCLES.
REQ-009 doubleClick  output  1  one-cycle pulse: two short presses within GAP_CYCLES.
REQ-010 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-011 stableSignal SHALL be registered once into sigQ; all FSM decisions SHALL use sigQ only.
REQ-012 FSM states: IDLE, PRESSED, LONG_HELD, WAIT_GAP, SECOND_PRESSED; one timer cnt (CNT_W bits) SHALL be cleared on every state entry.
REQ-013 IDLE: sigQ=1 -> PRESSED; otherwise stay.
REQ-014 PRESSED, sigQ=1, cnt==LONG_CYCLES-1 -> LONG_HELD with longPress pulse; sigQ=1 otherwise -> cnt+1.
REQ-015 PRESSED, sigQ=0 -> WAIT_GAP (DOUBLE_CLICK_EN defined) or IDLE with shortPress pulse (undefined); release SHALL win when sigQ=0 coincides with cnt==LONG_CYCLES-1.
REQ-016 LONG_HELD: stay while sigQ=1, no further pulses; sigQ=0 -> IDLE.
REQ-017 WAIT_GAP: sigQ=1 -> SECOND_PRESSED; sigQ=0 and cnt==GAP_CYCLES-1 -> IDLE with shortPress pulse; otherwise cnt+1; repress wins on coincidence.
REQ-018 SECOND_PRESSED: sigQ=0 -> IDLE with doubleClick pulse, regardless of hold duration; no longPress from this state.
REQ-019 Pulse outputs SHALL be registered, high exactly one cycle, asserted in the cycle after the transitioning edge; at most one pulse output high in any cycle.
REQ-020 Latency: with stableSignal first sampled 1 at edge k and held, longPress SHALL be high after edge k+LONG_CYCLES+1.
REQ-021 cnt SHALL never wrap; it saturates only via the exits in REQ-014/017.

Reset
REQ-022 reset=1 SHALL immediately force state=IDLE, cnt=0, sigQ=0, all outputs 0, independent of clk.
REQ-023 Reset mid-operation SHALL discard the pending event with no pulse; a button held through reset release SHALL be classified as a new press.

Configuration
REQ-024 Macro DOUBLE_CLICK_EN: defined -> full FSM per REQ-012..018; undefined -> WAIT_GAP and SECOND_PRESSED not synthesised, shortPress on release per REQ-015, doubleClick tied to 0, port list unchanged.

Structure
REQ-025 Package button_event_pkg SHALL hold the state enum typedef and the default LONG_CYCLES/GAP_CYCLES/CNT_W constants.
REQ-026 Sub-module event_timer (clear, enable, terminal-count compare, CNT_W bits) SHALL implement cnt; FSM stays in the top module.

Verification (LONG_CYCLES=8, GAP_CYCLES=6, 10 ns clk)
REQ-027 Reset held 3 cycles, stableSignal=0 -> all outputs 0, busy=0 throughout.
REQ-028 stableSignal high 3 cycles then low 20 -> exactly one shortPress (after gap timeout if DOUBLE_CLICK_EN, else 2 cycles after release), no other pulses.
REQ-029 stableSignal high 15 cycles -> one longPress exactly 9 cycles after first sampling edge; no pulse on release; busy returns 0.
REQ-030 High 3, low 3, high 3, low 20 -> one doubleClick 2 cycles after second release, no shortPress (DOUBLE_CLICK_EN); without macro -> two shortPress pulses, doubleClick never 1.
REQ-031 High 8 cycles exactly (release coincides with terminal count) -> classified short, no longPress.
REQ-032 reset pulsed while in PRESSED at cnt=5, stableSignal held high -> no pulse from aborted press; longPress 9 cycles after reset release sampling.

Source files
------------

// File: rtl/button_event_pkg.sv
// button_event_pkg: shared state encoding and default timing constants for the button event classifier.
package button_event_pkg;

    localparam int LONG_CYCLES_DEF = 50_000_000;
    localparam int GAP_CYCLES_DEF  = 25_000_000;
    localparam int CNT_W_DEF       = 26;

    typedef enum logic [2:0] {
        IDLE,
        PRESSED,
        LONG_HELD,
        WAIT_GAP,
        SECOND_PRESSED
    } state_t;

endpackage

// File: rtl/event_timer.sv
// event_timer: clearable, enabled up-counter with a terminal-count compare against a supplied limit.
module event_timer #(
    parameter int CNT_W = 26
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    input  logic [CNT_W-1:0] limit,
    output logic [CNT_W-1:0] cnt,
    output logic             done
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (clear)
            cnt <= '0;
        else if (enable)
            cnt <= cnt + 1'b1;
    end

    assign done = cnt == limit;

endmodule

// File: rtl/button_event_classifier.sv
// button_event_classifier: classifies a debounced button into short/long/double-click pulses.
// Define DOUBLE_CLICK_EN to build the double-click path (WAIT_GAP/SECOND_PRESSED).
module button_event_classifier
    import button_event_pkg::*;
#(
    parameter int LONG_CYCLES = LONG_CYCLES_DEF,
    parameter int GAP_CYCLES  = GAP_CYCLES_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic stableSignal,
    output logic shortPress,
    output logic longPress,
    output logic doubleClick,
    output logic busy
);

    state_t           state, state_n;
    logic             sigQ;
    logic             short_n, long_n, dbl_n;
    logic             enable, done;
    logic [CNT_W-1:0] cnt, limit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sigQ        <= 1'b0;
            state       <= IDLE;
            shortPress  <= 1'b0;
            longPress   <= 1'b0;
            doubleClick <= 1'b0;
        end else begin
            sigQ        <= stableSignal;
            state       <= state_n;
            shortPress  <= short_n;
            longPress   <= long_n;
            doubleClick <= dbl_n;
        end
    end

    // Release and repress are tested before the terminal count so they win on coincidence.
    always_comb begin
        state_n = state;
        short_n = 1'b0;
        long_n  = 1'b0;
        dbl_n   = 1'b0;
        enable  = 1'b0;
        case (state)
            IDLE:
                if (sigQ) state_n = PRESSED;
            PRESSED:
                if (!sigQ) begin
`ifdef DOUBLE_CLICK_EN
                    state_n = WAIT_GAP;
`else
                    state_n = IDLE;
                    short_n = 1'b1;
`endif
                end else if (done) begin
                    state_n = LONG_HELD;
                    long_n  = 1'b1;
                end else
                    enable = 1'b1;
            LONG_HELD:
                if (!sigQ) state_n = IDLE;
`ifdef DOUBLE_CLICK_EN
            WAIT_GAP:
                if (sigQ)
                    state_n = SECOND_PRESSED;
                else if (done) begin
                    state_n = IDLE;
                    short_n = 1'b1;
                end else
                    enable = 1'b1;
            SECOND_PRESSED:
                if (!sigQ) begin
                    state_n = IDLE;
                    dbl_n   = 1'b1;
                end
`endif
            default:
                state_n = IDLE;
        endcase
    end

    assign limit = (state == PRESSED) ? CNT_W'(LONG_CYCLES - 1) : CNT_W'(GAP_CYCLES - 1);
    assign busy  = state != IDLE;

    event_timer #(.CNT_W(CNT_W)) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (state_n != state),
        .enable (enable),
        .limit  (limit),
        .cnt    (cnt),
        .done   (done)
    );

endmodule

// File: tb/tb_button_event_classifier.sv
// tb_button_event_classifier: directed and randomized checks against a run-length reference model.
module tb_button_event_classifier;

    localparam int L = 8;
    localparam int G = 6;
`ifdef DOUBLE_CLICK_EN
    localparam bit DBL = 1'b1;
`else
    localparam bit DBL = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic stableSignal = 1'b0;
    logic shortPress, longPress, doubleClick, busy;

    int vectors = 0;
    int miscompares = 0;
    int n = 0;
    bit stim [1024];
    bit es [1024];
    bit el [1024];
    bit ed [1024];
    bit eb [1024];

    always #5 clk = ~clk;

    button_event_classifier #(.LONG_CYCLES(L), .GAP_CYCLES(G), .CNT_W(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .stableSignal (stableSignal),
        .shortPress   (shortPress),
        .longPress    (longPress),
        .doubleClick  (doubleClick),
        .busy         (busy)
    );

    task automatic chk(input string tag, input int idx, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s[%0d] observed=%b expected=%b", tag, idx, obs, exp);
        end
    endtask

    task automatic chk4(input int idx, input bit s, input bit l, input bit d, input bit b);
        chk("shortPress", idx, shortPress, s);
        chk("longPress", idx, longPress, l);
        chk("doubleClick", idx, doubleClick, d);
        chk("busy", idx, busy, b);
    endtask

    task automatic add(input bit v, input int len);
        for (int i = 0; i < len; i++) begin
            stim[n] = v;
            n++;
        end
    endtask

    function automatic int runlen(input int from, input bit v);
        int k = from;
        while (k < n && stim[k] == v) k++;
        return k - from;
    endfunction

    // Model: sample i is taken at edge i; each high run of length h starting at t is
    // long if h > L, else short on release, or (double-click build) paired with a
    // following run when the low gap is at most G samples.
    task automatic build_expect();
        int t, h, g, x, h2, e, nt;
        for (int i = 0; i < 1024; i++) begin
            es[i] = 0; el[i] = 0; ed[i] = 0; eb[i] = 0;
        end
        t = 0;
        while (t < n) begin
            if (!stim[t]) begin
                t++;
                continue;
            end
            h = runlen(t, 1'b1);
            nt = t + h;
            if (h >= L + 1) begin
                el[t + L + 1] = 1;
                e = t + h + 1;
            end else if (!DBL) begin
                es[t + h + 1] = 1;
                e = t + h + 1;
            end else begin
                g = runlen(t + h, 1'b0);
                if (g <= G) begin
                    x = t + h + g;
                    h2 = runlen(x, 1'b1);
                    ed[x + h2 + 1] = 1;
                    e = x + h2 + 1;
                    nt = x + h2;
                end else begin
                    es[t + h + 1 + G] = 1;
                    e = t + h + 1 + G;
                end
            end
            for (int i = t + 1; i < e; i++) eb[i] = 1;
            t = nt;
        end
    endtask

    task automatic run_seq();
        build_expect();
        for (int i = 0; i < n; i++) begin
            stableSignal = stim[i];
            @(posedge clk);
            #1;
            chk4(i, es[i], el[i], ed[i], eb[i]);
            @(negedge clk);
        end
        n = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        stableSignal = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk4(i, 0, 0, 0, 0);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        do_reset();
        add(1, 3);  add(0, 20); run_seq();
        do_reset();
        add(1, 15); add(0, 20); run_seq();
        do_reset();
        add(1, 3);  add(0, 3);  add(1, 3);  add(0, 20); run_seq();
        do_reset();
        add(1, 8);  add(0, 20); run_seq();
        add(1, 9);  add(0, 20); run_seq();
        add(1, 3);  add(0, G);  add(1, 2);  add(0, 20); run_seq();
        add(1, 2);  add(0, G + 1); add(1, 4); add(0, 20); run_seq();
        add(1, 2);  add(0, 2);  add(1, 12); add(0, 20); run_seq();
        for (int r = 0; r < 8; r++) begin
            for (int k = 0; k < 6; k++) begin
                add(1, $urandom_range(1, 12));
                add(0, $urandom_range(1, 9));
            end
            add(0, 25);
            run_seq();
        end
        // Abort a press at cnt=5 with the button held through reset.
        stableSignal = 1'b1;
        for (int i = 0; i < 7; i++) begin
            @(posedge clk);
            #1;
            chk4(100 + i, 0, 0, 0, i >= 1);
        end
        #2;
        reset = 1'b1;
        #1;
        chk4(200, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        chk4(201, 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b0;
        add(1, 15); add(0, 20); run_seq();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
